// File: rtl/wvb_reader_if.sv
// Signal bundle between the waveform-buffer reader and its surroundings:
// header FIFO, waveform buffer read port, output stream and status.
interface wvb_reader_if #(
    parameter int unsigned P_DATA_WIDTH = 22,
    parameter int unsigned P_ADR_WIDTH  = 12,
    parameter int unsigned P_HDR_WIDTH  = 80
);
    logic                    en;
    logic                    hdr_empty;
    logic                    hdr_rdreq;
    logic [P_HDR_WIDTH-1:0]  hdr_data;
    logic [P_ADR_WIDTH-1:0]  wvb_rd_addr;
    logic [P_DATA_WIDTH-1:0] wvb_data;
    logic [P_DATA_WIDTH-1:0] dout_data;
    logic                    dout_valid;
    logic                    dout_ready;
    logic                    dout_sop;
    logic                    dout_eop;
    logic [P_HDR_WIDTH-1:0]  hdr_out;
    logic                    busy;
    logic                    eoe_err;
    logic [15:0]             n_wvf_read;

    modport master (
        input  en, hdr_empty, hdr_data, wvb_data, dout_ready,
        output hdr_rdreq, wvb_rd_addr, dout_data, dout_valid, dout_sop, dout_eop,
               hdr_out, busy, eoe_err, n_wvf_read
    );

    modport slave (
        output en, hdr_empty, hdr_data, wvb_data, dout_ready,
        input  hdr_rdreq, wvb_rd_addr, dout_data, dout_valid, dout_sop, dout_eop,
               hdr_out, busy, eoe_err, n_wvf_read
    );
endinterface

// File: rtl/wvb_reader.sv
// Pops a waveform header, reads start..stop from the waveform buffer and streams the words
// out through a 4-entry skid FIFO with sop/eop framing and end-of-event checking.
module wvb_reader #(
    parameter int unsigned P_DATA_WIDTH = 22,
    parameter int unsigned P_ADR_WIDTH  = 12,
    parameter int unsigned P_HDR_WIDTH  = 80,
    parameter int unsigned P_HDR_LAT    = 2,
    parameter int unsigned P_BUF_LAT    = 1
) (
    input logic          clk,
    input logic          rst,
    wvb_reader_if.master bus
);
    localparam int unsigned LP_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {StIdle, StHdrWait, StRead, StDrain} state_e;

    state_e                  r_state;
    logic                    r_hdr_rdreq;
    logic [7:0]              r_lat_cnt;
    logic [P_HDR_WIDTH-1:0]  r_hdr_out;
    logic [P_ADR_WIDTH-1:0]  r_addr;
    logic [P_ADR_WIDTH-1:0]  r_stop;
    logic [P_ADR_WIDTH-1:0]  r_rd_addr;
    logic                    r_first;
    logic [15:0]             r_n_wvf;
    logic                    r_eoe_err;

    // Stage i holds the tag of the read whose data is valid i cycles after its address.
    logic [P_BUF_LAT:0]      r_pipe_vld;
    logic [P_BUF_LAT:0]      r_pipe_sop;
    logic [P_BUF_LAT:0]      r_pipe_eop;

    logic [P_DATA_WIDTH-1:0] r_mem_data [LP_FIFO_DEPTH];
    logic [LP_FIFO_DEPTH-1:0] r_mem_sop;
    logic [LP_FIFO_DEPTH-1:0] r_mem_eop;
    logic [1:0]              r_wr_ptr;
    logic [1:0]              r_rd_ptr;
    logic [2:0]              r_count;

    logic [7:0]              w_inflight;
    logic [7:0]              w_outstanding;
    logic                    w_issue;
    logic                    w_last_issue;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_pop_eop;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i <= int'(P_BUF_LAT); i++) begin
            w_inflight = w_inflight + {7'd0, r_pipe_vld[i]};
        end
    end

    // Reads in flight plus queued words never exceed the FIFO depth, so nothing is dropped.
    assign w_outstanding = w_inflight + {5'd0, r_count};
    assign w_issue       = (r_state == StRead) && (w_outstanding < 8'(LP_FIFO_DEPTH));
    assign w_last_issue  = w_issue && (r_addr == r_stop);
    assign w_push        = r_pipe_vld[P_BUF_LAT];
    assign w_pop         = (r_count != 3'd0) && bus.dout_ready;
    assign w_pop_eop     = w_pop && r_mem_eop[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_hdr_rdreq <= 1'b0;
            r_lat_cnt   <= '0;
            r_hdr_out   <= '0;
            r_addr      <= '0;
            r_stop      <= '0;
            r_rd_addr   <= '0;
            r_first     <= 1'b0;
            r_n_wvf     <= '0;
        end else begin
            r_hdr_rdreq <= 1'b0;
            if (w_pop_eop) begin
                r_n_wvf <= r_n_wvf + 16'd1;
            end
            unique case (r_state)
                StIdle: begin
                    if (bus.en && !bus.hdr_empty) begin
                        r_hdr_rdreq <= 1'b1;
                        r_lat_cnt   <= '0;
                        r_state     <= StHdrWait;
                    end
                end
                StHdrWait: begin
                    if (r_lat_cnt == 8'(P_HDR_LAT)) begin
                        r_hdr_out <= bus.hdr_data;
                        r_addr    <= bus.hdr_data[P_ADR_WIDTH-1:0];
                        r_stop    <= bus.hdr_data[2*P_ADR_WIDTH-1:P_ADR_WIDTH];
                        r_first   <= 1'b1;
                        r_state   <= StRead;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 8'd1;
                    end
                end
                StRead: begin
                    if (w_issue) begin
                        r_rd_addr <= r_addr;
                        r_addr    <= r_addr + P_ADR_WIDTH'(1);
                        r_first   <= 1'b0;
                        if (w_last_issue) begin
                            r_state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (w_pop_eop) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld <= '0;
            r_pipe_sop <= '0;
            r_pipe_eop <= '0;
            for (int i = 0; i < int'(LP_FIFO_DEPTH); i++) begin
                r_mem_data[i] <= '0;
            end
            r_mem_sop <= '0;
            r_mem_eop <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_eoe_err <= 1'b0;
        end else begin
            r_pipe_vld[0] <= w_issue;
            r_pipe_sop[0] <= w_issue && r_first;
            r_pipe_eop[0] <= w_last_issue;
            for (int i = 1; i <= int'(P_BUF_LAT); i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_sop[i] <= r_pipe_sop[i-1];
                r_pipe_eop[i] <= r_pipe_eop[i-1];
            end
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= bus.wvb_data;
                r_mem_sop[r_wr_ptr]  <= r_pipe_sop[P_BUF_LAT];
                r_mem_eop[r_wr_ptr]  <= r_pipe_eop[P_BUF_LAT];
                r_wr_ptr             <= r_wr_ptr + 2'd1;
                // Bit 0 of the buffer word must mark exactly the last word of the waveform.
                if (bus.wvb_data[0] != r_pipe_eop[P_BUF_LAT]) begin
                    r_eoe_err <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.hdr_rdreq   = r_hdr_rdreq;
    assign bus.wvb_rd_addr = r_rd_addr;
    assign bus.dout_data   = r_mem_data[r_rd_ptr];
    assign bus.dout_valid  = (r_count != 3'd0);
    assign bus.dout_sop    = r_mem_sop[r_rd_ptr];
    assign bus.dout_eop    = r_mem_eop[r_rd_ptr];
    assign bus.hdr_out     = r_hdr_out;
    assign bus.busy        = (r_state != StIdle);
    assign bus.eoe_err     = r_eoe_err;
    assign bus.n_wvf_read  = r_n_wvf;
endmodule

// File: tb/tb_wvb_reader.sv
// Directed bench for wvb_reader: header FIFO and buffer models, stream monitor,
// and hand-computed expectations for each scenario.
module tb_wvb_reader;
    localparam int unsigned DW   = 22;
    localparam int unsigned AW   = 12;
    localparam int unsigned HW   = 80;
    localparam int unsigned HLAT = 2;
    localparam int unsigned BLAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wvb_reader_if #(.P_DATA_WIDTH(DW), .P_ADR_WIDTH(AW), .P_HDR_WIDTH(HW)) bus ();

    wvb_reader #(
        .P_DATA_WIDTH(DW),
        .P_ADR_WIDTH (AW),
        .P_HDR_WIDTH (HW),
        .P_HDR_LAT   (HLAT),
        .P_BUF_LAT   (BLAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] a, input logic e);
        return {a, 9'h15A, e};
    endfunction

    function automatic logic [HW-1:0] make_hdr(input int idx, input logic [AW-1:0] start,
                                               input logic [AW-1:0] stop);
        return {56'hA5C3_0000_0000_00 + 56'(idx), stop, start};
    endfunction

    // Buffer (one-cycle synchronous read) and header FIFO (data valid HLAT cycles after pop).
    logic [DW-1:0] buf_mem [4096];
    logic [HW-1:0] hdr_tab [16];
    logic [HW-1:0] hdr_pend;
    int   hdr_wr = 0;
    int   hdr_rd = 0;
    int   hdr_cd = 0;
    int   n_rdreq = 0;
    logic rdreq_empty_viol = 1'b0;

    assign bus.hdr_empty = (hdr_wr == hdr_rd);

    always @(posedge clk) begin
        bus.wvb_data <= buf_mem[bus.wvb_rd_addr];
        if (bus.hdr_rdreq) begin
            if (hdr_wr == hdr_rd) rdreq_empty_viol <= 1'b1;
            hdr_pend     <= hdr_tab[hdr_rd[3:0]];
            hdr_rd       <= hdr_rd + 1;
            n_rdreq      <= n_rdreq + 1;
            hdr_cd       <= int'(HLAT) - 1;
            bus.hdr_data <= '1;
        end else if (hdr_cd == 1) begin
            bus.hdr_data <= hdr_pend;
            hdr_cd       <= 0;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stream monitor, sampled mid-cycle.
    logic [DW-1:0]   rec_data [64];
    logic            rec_sop  [64];
    logic            rec_eop  [64];
    int              rec_cyc  [64];
    int              rec_n = 0;
    logic            mon_track = 1'b0;
    int              n_iss = 0;
    int              n_acc = 0;
    int              max_out = 0;
    logic [AW-1:0]   prev_addr = '0;
    logic            prev_stall = 1'b0;
    logic [DW+1:0]   prev_word = '0;
    int              n_hold_err = 0;

    always @(negedge clk) begin
        if (!mon_track) begin
            n_iss     = 0;
            n_acc     = 0;
            max_out   = 0;
            prev_addr = bus.wvb_rd_addr;
        end else begin
            if (bus.wvb_rd_addr != prev_addr) n_iss++;
            prev_addr = bus.wvb_rd_addr;
            if (n_iss - n_acc > max_out) max_out = n_iss - n_acc;
        end
        if (prev_stall && !rst) begin
            if (!bus.dout_valid || ({bus.dout_data, bus.dout_sop, bus.dout_eop} !== prev_word))
                n_hold_err++;
        end
        prev_stall = bus.dout_valid && !bus.dout_ready && !rst;
        prev_word  = {bus.dout_data, bus.dout_sop, bus.dout_eop};
        if (bus.dout_valid && bus.dout_ready && !rst) begin
            if (rec_n < 64) begin
                rec_data[rec_n] = bus.dout_data;
                rec_sop[rec_n]  = bus.dout_sop;
                rec_eop[rec_n]  = bus.dout_eop;
                rec_cyc[rec_n]  = cyc;
            end
            rec_n++;
            if (mon_track) n_acc++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_hdr(input logic [AW-1:0] start, input logic [AW-1:0] stop);
        hdr_tab[hdr_wr[3:0]] = make_hdr(hdr_wr, start, stop);
        hdr_wr++;
    endtask

    task automatic wait_wvf(input string tag, input logic [15:0] target);
        int guard;
        guard = 0;
        while (!(bus.n_wvf_read == target && !bus.busy) && guard < 400) begin
            tick(1);
            guard++;
        end
        check_eq({tag, "_n_wvf"}, 128'(bus.n_wvf_read), 128'(target));
        check_eq({tag, "_idle"}, 128'(bus.busy), 128'(0));
    endtask

    task automatic check_wave(input string tag, input int base, input logic [AW-1:0] start,
                              input int n, input logic eoe_last);
        check_eq({tag, "_nwords"}, 128'(rec_n - base), 128'(n));
        for (int k = 0; k < n && base + k < 64; k++) begin
            check_eq($sformatf("%s_w%0d", tag, k),
                     128'({rec_data[base+k], rec_sop[base+k], rec_eop[base+k]}),
                     128'({exp_word(start + AW'(k), (k == n - 1) && eoe_last),
                           k == 0, k == n - 1}));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"},   128'(bus.busy),        128'(0));
        check_eq({tag, "_valid"},  128'(bus.dout_valid),  128'(0));
        check_eq({tag, "_rdreq"},  128'(bus.hdr_rdreq),   128'(0));
        check_eq({tag, "_sopeop"}, 128'({bus.dout_sop, bus.dout_eop}), 128'(0));
        check_eq({tag, "_eoeerr"}, 128'(bus.eoe_err),     128'(0));
        check_eq({tag, "_nwvf"},   128'(bus.n_wvf_read),  128'(0));
        check_eq({tag, "_rdaddr"}, 128'(bus.wvb_rd_addr), 128'(0));
        check_eq({tag, "_data"},   128'(bus.dout_data),   128'(0));
        check_eq({tag, "_hdrout"}, 128'(bus.hdr_out),     128'(0));
    endtask

    initial begin
        int base;
        int rq0;
        int guard;
        logic [15:0] lfsr;

        bus.en         = 1'b0;
        bus.dout_ready = 1'b1;
        for (int a = 0; a < 4096; a++) buf_mem[a] = exp_word(AW'(a), 1'b0);
        buf_mem[12'h013] = exp_word(12'h013, 1'b1);
        buf_mem[12'h001] = exp_word(12'h001, 1'b1);
        buf_mem[12'h20F] = exp_word(12'h20F, 1'b1);
        buf_mem[12'h30F] = exp_word(12'h30F, 1'b1);
        buf_mem[12'h40F] = exp_word(12'h40F, 1'b1);
        buf_mem[12'h502] = exp_word(12'h502, 1'b1);

        rst = 1'b1;
        tick(3);
        check_reset_outputs("por");
        rst = 1'b0;
        bus.en = 1'b1;
        tick(2);

        // Basic 4-word waveform.
        base = rec_n;
        push_hdr(12'h010, 12'h013);
        wait_wvf("basic", 16'd1);
        check_eq("basic_rdreq", 128'(n_rdreq), 128'(1));
        check_wave("basic", base, 12'h010, 4, 1'b1);
        check_eq("basic_consec", 128'(rec_cyc[base+3] - rec_cyc[base]), 128'(3));
        check_eq("basic_hdr_out", 128'(bus.hdr_out), 128'(make_hdr(0, 12'h010, 12'h013)));
        check_eq("basic_eoe_err", 128'(bus.eoe_err), 128'(0));

        // Address wrap.
        base = rec_n;
        push_hdr(12'hFFE, 12'h001);
        wait_wvf("wrap", 16'd2);
        check_wave("wrap", base, 12'hFFE, 4, 1'b1);
        check_eq("wrap_eoe_err", 128'(bus.eoe_err), 128'(0));

        // Backpressure, 16 words.
        base = rec_n;
        mon_track = 1'b1;
        tick(1);
        push_hdr(12'h200, 12'h20F);
        lfsr  = 16'hACE1;
        guard = 0;
        while (!(bus.n_wvf_read == 16'd3 && !bus.busy) && guard < 600) begin
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            bus.dout_ready = lfsr[0] | lfsr[5];
            tick(1);
            guard++;
        end
        bus.dout_ready = 1'b1;
        check_eq("bp_n_wvf", 128'(bus.n_wvf_read), 128'(3));
        check_wave("bp", base, 12'h200, 16, 1'b1);
        check_eq("bp_max_out_le4", 128'(max_out <= 4), 128'(1));
        check_eq("bp_hold", 128'(n_hold_err), 128'(0));
        mon_track = 1'b0;

        // Length 1 with a missing eoe flag.
        base = rec_n;
        push_hdr(12'h100, 12'h100);
        wait_wvf("len1", 16'd4);
        check_wave("len1", base, 12'h100, 1, 1'b0);
        check_eq("len1_eoe_err", 128'(bus.eoe_err), 128'(1));

        // en dropped mid-waveform with three headers queued.
        base = rec_n;
        rq0  = n_rdreq;
        push_hdr(12'h300, 12'h30F);
        push_hdr(12'h400, 12'h40F);
        push_hdr(12'h500, 12'h502);
        guard = 0;
        while (rec_n < base + 2 && guard < 100) begin
            tick(1);
            guard++;
        end
        bus.en = 1'b0;
        wait_wvf("endrop", 16'd5);
        tick(20);
        check_eq("endrop_rdreq", 128'(n_rdreq - rq0), 128'(1));
        check_eq("endrop_queued", 128'(hdr_wr - hdr_rd), 128'(2));
        check_eq("endrop_busy", 128'(bus.busy), 128'(0));
        check_wave("endrop", base, 12'h300, 16, 1'b1);

        // Reset while stalled in READ with the skid FIFO full.
        bus.dout_ready = 1'b0;
        bus.en = 1'b1;
        rq0 = n_rdreq;
        guard = 0;
        while (n_rdreq == rq0 && guard < 50) begin
            tick(1);
            guard++;
        end
        bus.en = 1'b0;
        tick(10);
        check_eq("rstmid_busy_before", 128'(bus.busy), 128'(1));
        check_eq("rstmid_valid_before", 128'(bus.dout_valid), 128'(1));
        rst = 1'b1;
        tick(1);
        check_reset_outputs("rstmid");
        rst = 1'b0;
        bus.dout_ready = 1'b1;
        tick(2);

        // Post-reset waveform must not carry stale words from the aborted one.
        base = rec_n;
        rq0  = n_rdreq;
        bus.en = 1'b1;
        wait_wvf("post", 16'd1);
        check_eq("post_rdreq", 128'(n_rdreq - rq0), 128'(1));
        check_wave("post", base, 12'h500, 3, 1'b1);
        check_eq("post_eoe_err", 128'(bus.eoe_err), 128'(0));

        check_eq("rdreq_when_empty", 128'(rdreq_empty_viol), 128'(0));
        check_eq("stream_hold", 128'(n_hold_err), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wvb_reader.md
WVB_READER -- requirements
Module: wvb_reader

Interface
REQ-001 Parameters (name, default, meaning): P_DATA_WIDTH, 22, waveform word width; P_ADR_WIDTH, 12, buffer address width; P_HDR_WIDTH, 80, header width; P_HDR_LAT, 2, cycles from hdr_rdreq to valid hdr_data; P_BUF_LAT, 1, cycles from wvb_rd_addr to valid wvb_data.
REQ-002 Ports, in order (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst, in, 1, synchronous active-high reset.
- en, in, 1, readout enable.
- hdr_empty, in, 1, header FIFO empty.
- hdr_rdreq, out, 1, header FIFO pop.
- hdr_data, in, P_HDR_WIDTH, header FIFO output.
- wvb_rd_addr, out, P_ADR_WIDTH, buffer read address.
- wvb_data, in, P_DATA_WIDTH, buffer read data; bit 0 is the end-of-event (eoe) flag.
- dout_data, out, P_DATA_WIDTH, streamed sample.
- dout_valid, out, 1, stream valid.
- dout_ready, in, 1, stream ready.
- dout_sop, out, 1, first word of a waveform.
- dout_eop, out, 1, last word of a waveform.
- hdr_out, out, P_HDR_WIDTH, header of the current waveform.
- busy, out, 1, readout in progress.
- eoe_err, out, 1, sticky eoe mismatch flag.
- n_wvf_read, out, 16, waveforms completed, wrapping.

Function
REQ-003 Header fields: start_addr = hdr_data[P_ADR_WIDTH-1:0]; stop_addr = hdr_data[2*P_ADR_WIDTH-1:P_ADR_WIDTH].
REQ-004 States: IDLE, HDR_WAIT, READ, DRAIN.
REQ-005 IDLE: when en=1 and hdr_empty=0, assert hdr_rdreq for exactly one cycle and go to HDR_WAIT; hdr_rdreq SHALL never be asserted when hdr_empty=1.
REQ-006 HDR_WAIT: count P_HDR_LAT cycles after the hdr_rdreq cycle, then capture hdr_data into hdr_out, load the address counter with start_addr, and go to READ.
REQ-007 hdr_out SHALL stay stable from capture until the next capture.
REQ-008 Waveform length SHALL be ((stop_addr - start_addr) mod 2^P_ADR_WIDTH) + 1 words; the address increments modulo 2^P_ADR_WIDTH (wrap from all-ones to 0 is legal).
REQ-009 Output path SHALL contain a 4-entry skid FIFO; in READ a read SHALL be issued (address driven, counter advanced) only when words in flight plus words queued < 4, so no word is ever dropped under backpressure.
REQ-010 Each returned word SHALL enter the skid FIFO exactly P_BUF_LAT cycles after its address was issued.
REQ-011 After the stop_addr read is issued, go to DRAIN; DRAIN SHALL return to IDLE on the cycle the eop word is accepted (dout_valid & dout_ready).
REQ-012 dout_valid SHALL follow AXI-stream rules: once asserted, dout_data, dout_sop and dout_eop SHALL hold until accepted.
REQ-013 dout_sop SHALL be 1 only on the first word of a waveform and dout_eop only on the last; for a length-1 waveform both SHALL be 1 on the same word.
REQ-014 eoe_err SHALL set if an eop word has bit 0 = 0 or a non-eop word has bit 0 = 1; it clears only on rst. Data SHALL pass through unmodified.
REQ-015 n_wvf_read SHALL increment by 1 on each eop acceptance.
REQ-016 busy SHALL be 1 in every state other than IDLE.
REQ-017 en deasserted in HDR_WAIT, READ or DRAIN SHALL NOT abort: the current waveform completes, and no new header is popped while en=0.
REQ-018 Throughput: with dout_ready held at 1, a waveform of N words SHALL stream as N consecutive valid cycles.

Reset
REQ-019 rst SHALL take effect on the next clk edge from any state and return the FSM to IDLE.
REQ-020 On rst, all outputs SHALL reset to 0: hdr_rdreq, dout_valid, dout_sop, dout_eop, busy, eoe_err, n_wvf_read, wvb_rd_addr, dout_data, hdr_out.
REQ-021 On rst, skid-FIFO contents and in-flight reads SHALL be discarded.

Verification
REQ-022 Basic: header start=0x010, stop=0x013, eoe on the last word, dout_ready=1 -> one hdr_rdreq pulse; 4 consecutive words from addr 0x010..0x013; sop on word 0, eop on word 3; n_wvf_read=1; eoe_err=0.
REQ-023 Wrap: start=0xFFE, stop=0x001 -> 4 words from addresses 0xFFE, 0xFFF, 0x000, 0x001, in that order.
REQ-024 Backpressure: 16-word waveform with dout_ready toggled pseudo-randomly -> all 16 words delivered in order, none duplicated or lost; at most 4 words outstanding at any time.
REQ-025 Length 1 and eoe error: start=stop=0x100 with eoe=0 -> a single word carrying sop=1 and eop=1; eoe_err=1 afterwards.
REQ-026 Control: en dropped mid-waveform with 3 headers queued -> the current waveform completes and no further hdr_rdreq is issued; rst asserted mid-READ -> next cycle busy=0, dout_valid=0, all outputs 0.
